freq_div_detector: RTL and testbench

// - Receive side of the frequency divider: measures an incoming divided square wave (sig_in) and recovers
//   the divide value that produced it, i.e. the value N for which sig_in toggles every N+1 clk cycles.
// - Used in the DPWM path to check/lock onto an externally divided clock; reports value, validity, lock, loss.

---
 rtl/freq_div_detector.sv | 169 ++++++++++++++++
 tb/tb_freq_div_detector.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_div_detector.sv
// rtl/freq_div_detector.sv - recovers divide value N from a square wave toggling every N+1 clk cycles
// Optional sticky lock-loss flag (ports err_sticky/clr_err) enabled by defining FDD_STICKY_ERR_EN.
module freq_div_detector #(
    parameter int WIDTH      = 6,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
`ifdef FDD_STICKY_ERR_EN
    input  logic             clr_err,
    output logic             err_sticky,
`endif
    output logic [WIDTH-1:0] div_value,
    output logic             div_valid,
    output logic             locked,
    output logic             no_signal
);
    localparam int            CW      = WIDTH + 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [3:0]    LOCK_N  = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             w_edge;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_div_value;
    logic [WIDTH-1:0] w_div_value_nx;
    logic             r_div_valid;
    logic             w_div_valid_nx;
    logic             r_locked;
    logic             w_locked_nx;
    logic             r_no_signal;
    logic             w_no_signal_nx;
    logic [3:0]       r_match_cnt;
    logic [3:0]       w_match_cnt_nx;
    logic [3:0]       w_match_inc;
    logic             w_in_range;
    logic             w_same;
    logic             w_timeout;

    // Both polarities of the synchronised input mark a half-period boundary.
    assign w_edge      = r_s2 ^ r_s3;
    assign w_in_range  = ~r_cnt[CW-1];
    assign w_same      = (r_cnt[WIDTH-1:0] == r_div_value);
    assign w_timeout   = ~w_edge && (r_cnt == CNT_MAX);
    assign w_match_inc = (w_same && (r_match_cnt != 4'd0)) ? r_match_cnt + 4'd1 : 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_s3  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_edge) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_div_value <= '0;
            r_div_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_no_signal <= 1'b1;
            r_match_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nx;
            r_div_value <= w_div_value_nx;
            r_div_valid <= w_div_valid_nx;
            r_locked    <= w_locked_nx;
            r_no_signal <= w_no_signal_nx;
            r_match_cnt <= w_match_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_div_value_nx = r_div_value;
        w_div_valid_nx = 1'b0;
        w_locked_nx    = r_locked;
        w_no_signal_nx = r_no_signal;
        w_match_cnt_nx = r_match_cnt;
        case (r_state)
            ST_IDLE: begin
                // First edge only opens a window; the period before it is partial.
                if (w_edge) begin
                    w_state_nx     = ST_MEASURE;
                    w_no_signal_nx = 1'b0;
                    w_match_cnt_nx = 4'd0;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (w_edge && w_in_range) begin
                    w_div_valid_nx = 1'b1;
                    if (r_state == ST_LOCKED) begin
                        if (!w_same) begin
                            w_div_value_nx = r_cnt[WIDTH-1:0];
                            w_locked_nx    = 1'b0;
                            w_match_cnt_nx = 4'd1;
                            w_state_nx     = ST_MEASURE;
                        end
                    end else begin
                        w_div_value_nx = r_cnt[WIDTH-1:0];
                        w_match_cnt_nx = w_match_inc;
                        if (w_match_inc == LOCK_N) begin
                            w_state_nx  = ST_LOCKED;
                            w_locked_nx = 1'b1;
                        end
                    end
                end else if (w_edge) begin
                    w_locked_nx    = 1'b0;
                    w_match_cnt_nx = 4'd0;
                    w_state_nx     = ST_MEASURE;
                end else if (w_timeout) begin
                    w_locked_nx    = 1'b0;
                    w_no_signal_nx = 1'b1;
                    w_state_nx     = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

`ifdef FDD_STICKY_ERR_EN
    logic r_err_sticky;
    logic w_lock_exit;

    // Every way out of LOCKED (mismatch, out of range, timeout) counts as a lock loss.
    assign w_lock_exit = (r_state == ST_LOCKED) && (w_state_nx != ST_LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_sticky <= 1'b0;
        end else if (w_lock_exit) begin
            r_err_sticky <= 1'b1;
        end else if (clr_err) begin
            r_err_sticky <= 1'b0;
        end
    end

    assign err_sticky = r_err_sticky;
`endif

    assign div_value = r_div_value;
    assign div_valid = r_div_valid;
    assign locked    = r_locked;
    assign no_signal = r_no_signal;

endmodule

// File: tb/tb_freq_div_detector.sv
// tb/tb_freq_div_detector.sv - randomized self-checking bench for freq_div_detector against a period-level model
module tb_freq_div_detector;
    localparam int WIDTH      = 6;
    localparam int LOCK_COUNT = 4;
    localparam int NMAX       = (1 << WIDTH) - 1;
    localparam int TMO_GAP    = 1 << (WIDTH + 1);

    typedef struct {
        int   val;
        logic vld;
        logic lck;
        logic nos;
        logic err_set;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             sig_in;
    logic             clr_err;
    logic [WIDTH-1:0] div_value;
    logic             div_valid;
    logic             locked;
    logic             no_signal;
    logic             err_sticky;

    int   n_total = 0;
    int   n_bad   = 0;
    logic lvl;

    exp_t exp_q[$];
    int   m_k;
    int   m_last_tr;
    logic m_prev;
    bit   m_active;
    int   m_run;
    int   m_val;
    logic m_err;

    always #5 clk = ~clk;

    freq_div_detector #(
        .WIDTH      (WIDTH),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sig_in     (sig_in),
`ifdef FDD_STICKY_ERR_EN
        .clr_err    (clr_err),
        .err_sticky (err_sticky),
`endif
        .div_value  (div_value),
        .div_valid  (div_valid),
        .locked     (locked),
        .no_signal  (no_signal)
    );

`ifndef FDD_STICKY_ERR_EN
    assign err_sticky = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.val     = m_val;
        e.vld     = 1'b0;
        e.lck     = (m_run >= LOCK_COUNT);
        e.nos     = !m_active;
        e.err_set = 1'b0;
        return e;
    endfunction

    // Model state is the signal history: gap since last transition and the run of equal periods.
    task automatic model_reset();
        m_k       = 0;
        m_last_tr = -3;
        m_prev    = 1'b0;
        m_active  = 1'b0;
        m_run     = 0;
        m_val     = 0;
        m_err     = 1'b0;
        exp_q.delete();
        exp_q.push_back(snapshot());
        exp_q.push_back(snapshot());
    endtask

    task automatic model_sample(input logic v);
        exp_t e;
        int   gap;
        int   n;
        bit   was_locked;
        bit   vld;
        bit   brk;
        gap        = m_k - m_last_tr;
        n          = gap - 1;
        was_locked = (m_run >= LOCK_COUNT);
        vld        = 1'b0;
        brk        = 1'b0;
        if (v != m_prev) begin
            if (!m_active) begin
                m_active = 1'b1;
                m_run    = 0;
            end else if (n <= NMAX) begin
                vld = 1'b1;
                if (m_run > 0 && n == m_val) begin
                    m_run++;
                end else begin
                    brk   = was_locked;
                    m_run = 1;
                end
                m_val = n;
            end else begin
                brk   = was_locked;
                m_run = 0;
            end
            m_last_tr = m_k;
        end else if (gap >= TMO_GAP && m_active) begin
            brk      = was_locked;
            m_active = 1'b0;
            m_run    = 0;
        end
        e         = snapshot();
        e.vld     = vld;
        e.err_set = brk;
        exp_q.push_back(e);
        m_prev = v;
        m_k++;
    endtask

    task automatic step(input logic v, input logic clr);
        exp_t e;
        sig_in  = v;
        clr_err = clr;
        model_sample(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.err_set) begin
            m_err = 1'b1;
        end else if (clr) begin
            m_err = 1'b0;
        end
        check("div_valid", div_valid, e.vld);
        check("div_value", div_value, e.val);
        check("locked", locked, e.lck);
        check("no_signal", no_signal, e.nos);
`ifdef FDD_STICKY_ERR_EN
        check("err_sticky", err_sticky, m_err);
`endif
        clr_err = 1'b0;
    endtask

    task automatic toggle_run(input int period, input int count);
        for (int i = 0; i < count; i++) begin
            lvl = ~lvl;
            step(lvl, 1'b0);
            for (int j = 1; j < period; j++) begin
                step(lvl, 1'b0);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_value"}, div_value, 0);
        check({tag, "_valid"}, div_valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_nosig"}, no_signal, 1);
        check({tag, "_err"}, err_sticky, 0);
    endtask

    initial begin
        int pause;
        reset   = 1'b0;
        sig_in  = 1'b0;
        clr_err = 1'b0;
        lvl     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b1;

        repeat (5) step(lvl, 1'b0);
        toggle_run(5, 12);
        check("lock_n4", locked, 1);
        check("value_n4", div_value, 4);

        toggle_run(10, 8);
        check("lock_n9", locked, 1);
        check("value_n9", div_value, 9);

        repeat (140) step(lvl, 1'b0);
        check("tmo_nosig", no_signal, 1);
        check("tmo_locked", locked, 0);
        check("tmo_value", div_value, 9);

        toggle_run(1, 10);
        check("lock_n0", locked, 1);
        check("value_n0", div_value, 0);

        toggle_run(64, 6);
        check("lock_n63", locked, 1);
        check("value_n63", div_value, 63);

        toggle_run(65, 3);
        check("oor_locked", locked, 0);
        check("oor_value", div_value, 63);
        check("oor_nosig", no_signal, 0);

        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 5) == 0) begin
                pause = $urandom_range(100, 160);
                repeat (pause) step(lvl, 1'b0);
            end
            toggle_run($urandom_range(1, 70), $urandom_range(1, 6));
        end

        toggle_run(3, 8);
        check("prerst_locked", locked, 1);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        sig_in = 1'b1;
        lvl    = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
        repeat (7) step(lvl, 1'b0);
        toggle_run(7, 6);
        check("lock_n6", locked, 1);
        check("value_n6", div_value, 6);

`ifdef FDD_STICKY_ERR_EN
        check("err_before", err_sticky, 0);
        toggle_run(5, 8);
        check("err_after_relock", err_sticky, 1);
        check("relock_n4", locked, 1);
        step(lvl, 1'b1);
        check("err_cleared", err_sticky, 0);
        repeat (4) step(lvl, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
